// File: rtl/dpcm_decoder_apb_if.sv
// dpcm_decoder_apb_if
// APB bus bundle for the DPCM decoder slave.
//   master : drives PSELx, PENABLE, PWRITE, PADDR, PWDATA; observes PREADY, PSLVERR, PRDATA
//   slave  : the mirror image of master
// PCLK and PRESETn are kept outside the bundle as plain ports of the slave.
interface dpcm_decoder_apb_if;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/dpcm_decoder_apb.sv
// dpcm_decoder_apb
// APB slave that rebuilds samples from a DPCM difference stream. Each DIFF
// write adds the difference to the previous reconstructed sample, clamps the
// result to [SAT_MIN, SAT_MAX] and queues it in an output FIFO that the host
// drains through SAMPLE reads.
//
// Ports:
//   PCLK      : clock, all state on the rising edge
//   PRESETn   : asynchronous reset, active HIGH despite the name
//   apb       : APB slave bundle (PSELx, PENABLE, PWRITE, PADDR, PWDATA,
//               PREADY, PSLVERR, PRDATA)
//   estados   : current FSM state (0 IDLE, 1 SETUP, 2 ACCESS), debug only
//   contador  : FIFO occupancy, 0..DEPTH
//
// Register map (PADDR[3:2], PADDR[31:4] must be zero):
//   0x0 DIFF   W  push one difference
//   0x4 SAMPLE R  pop oldest sample
//   0x8 STATUS R  [0] empty [1] full [2] sticky sat [15:8] occupancy
//   0xC CTRL   W  [0] clear predictor [1] clear sat [2] flush FIFO
module dpcm_decoder_apb #(
  parameter int SAT_MAX = 32767,
  parameter int SAT_MIN = -32768,
  parameter int DEPTH   = 8
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  dpcm_decoder_apb_if.slave        apb,
  output logic [1:0]               estados,
  output logic [$clog2(DEPTH):0]   contador
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]          FULL_CNT  = DEPTH[PW:0];
  localparam logic signed [32:0]   SAT_MAX_X = 33'(SAT_MAX);
  localparam logic signed [32:0]   SAT_MIN_X = 33'(SAT_MIN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [31:0] pred;
  logic               sat;
  logic signed [31:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        count;

  logic [31:0]        prdata_q;
  logic               pslverr_q;

  logic               transfer_on;
  logic               empty, full;
  logic [1:0]         sel;
  logic [7:0]         occ;
  logic [31:0]        status_word;
  logic               dec_err;
  logic [31:0]        dec_data;
  logic signed [32:0] sum;
  logic signed [31:0] y;
  logic               clipped;
  logic               commit;
  logic               unused_addr_lsbs;

  assign transfer_on      = apb.PSELx && apb.PENABLE;
  assign empty            = (count == '0);
  assign full             = (count == FULL_CNT);
  assign sel              = apb.PADDR[3:2];
  assign occ              = 8'(count);
  assign status_word      = {16'd0, occ, 5'd0, sat, full, empty};
  assign unused_addr_lsbs = ^apb.PADDR[1:0];

  // State register.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic. SETUP is the single wait cycle (PREADY low); ACCESS is
  // the completing cycle. Losing PSELx/PENABLE during the wait cycle aborts.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (apb.PSELx) state_next = SETUP;
      SETUP:   state_next = transfer_on ? ACCESS : IDLE;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address/direction decode: works out the error flag and read data the
  // transfer will return, from the state as it stands before any commit.
  always_comb begin
    dec_err  = 1'b1;
    dec_data = '0;
    if (apb.PADDR[31:4] == 28'd0) begin
      if (apb.PWRITE) begin
        case (sel)
          2'd0:    dec_err = full;
          2'd3:    dec_err = 1'b0;
          default: dec_err = 1'b1;
        endcase
      end else begin
        case (sel)
          2'd1: begin
            dec_err = empty;
            if (!empty) dec_data = mem[rd_ptr];
          end
          2'd2: begin
            dec_err  = 1'b0;
            dec_data = status_word;
          end
          default: dec_err = 1'b1;
        endcase
      end
    end
  end

  // Reconstruction: 33-bit sum so the addition cannot wrap before clamping.
  always_comb begin
    sum     = {pred[31], pred} + {apb.PWDATA[31], apb.PWDATA};
    y       = sum[31:0];
    clipped = 1'b0;
    if (sum > SAT_MAX_X) begin
      y       = SAT_MAX_X[31:0];
      clipped = 1'b1;
    end else if (sum < SAT_MIN_X) begin
      y       = SAT_MIN_X[31:0];
      clipped = 1'b1;
    end
  end

  // Side effects happen only at the end of an unaborted, error-free completing cycle.
  assign commit = (state == ACCESS) && transfer_on && !pslverr_q;

  // Response registers: launched on the edge into ACCESS, zero otherwise.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else if (state == SETUP && transfer_on) begin
      prdata_q  <= dec_err ? 32'd0 : dec_data;
      pslverr_q <= dec_err;
    end else begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end
  end

  // Predictor, sticky flag and FIFO bookkeeping. The only error-free writes
  // are DIFF and CTRL, and the only error-free read with a side effect is SAMPLE.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      pred   <= '0;
      sat    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (commit) begin
      if (apb.PWRITE) begin
        if (sel == 2'd0) begin
          pred   <= y;
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
          if (clipped) sat <= 1'b1;
        end else begin
          if (apb.PWDATA[2]) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
          end
          if (apb.PWDATA[0]) pred <= '0;
          if (apb.PWDATA[1]) sat  <= 1'b0;
        end
      end else if (sel == 2'd1) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

  // FIFO storage has no reset; only the pointers define its contents.
  always_ff @(posedge PCLK) begin
    if (commit && apb.PWRITE && sel == 2'd0) mem[wr_ptr] <= y;
  end

  assign apb.PREADY  = (state != SETUP);
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;
  assign estados     = state;
  assign contador    = count;

endmodule

// File: tb/tb_dpcm_decoder_apb.sv
// tb_dpcm_decoder_apb
// Table-driven bench for dpcm_decoder_apb: a list of APB transfers with
// hand-computed PRDATA/PSLVERR, plus hand-written sequences for reset
// values, protocol abort and reset in the middle of a transfer.
module tb_dpcm_decoder_apb;

  logic       PCLK;
  logic       PRESETn;
  logic [1:0] estados;
  logic [3:0] contador;

  dpcm_decoder_apb_if apb();

  dpcm_decoder_apb #(.SAT_MAX(32767), .SAT_MIN(-32768), .DEPTH(8)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .apb      (apb.slave),
    .estados  (estados),
    .contador (contador)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   checks_total;
  int   checks_passed;

  // Compare one value and log a failure line if it differs.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  function automatic void addVec(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  // One complete APB transfer, followed by one idle cycle. Checks that the
  // slave inserts exactly one wait state and returns the completion values.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err);
    int n;
    @(posedge PCLK); #1;
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wdata;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    n = 0;
    while (!apb.PREADY && n < 8) begin
      @(posedge PCLK); #1;
      n++;
    end
    checkOutput("wait_states", 32'(n), 32'd1);
    rdata = apb.PRDATA;
    err   = apb.PSLVERR;
    @(posedge PCLK); #1;
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    checks_total  = 0;
    checks_passed = 0;

    // Vector table, applied in order; state carries from one row to the next.
    addVec(0, 32'h8, 0, 32'h1, 0);                 // STATUS after reset
    addVec(1, 32'h0, 32'd100, 0, 0);
    addVec(1, 32'h0, -32'sd30, 0, 0);
    addVec(1, 32'h0, 32'd5, 0, 0);
    addVec(0, 32'h4, 0, 32'd100, 0);
    addVec(0, 32'h4, 0, 32'd70, 0);
    addVec(0, 32'h4, 0, 32'd75, 0);
    addVec(0, 32'h8, 0, 32'h1, 0);
    addVec(1, 32'hC, 32'h1, 0, 0);                 // predictor to 0
    addVec(1, 32'h0, 32'd32000, 0, 0);
    addVec(1, 32'h0, 32'd1000, 0, 0);              // 33000 clamps to 32767
    addVec(0, 32'h8, 0, 32'h0000_0204, 0);         // 2 queued, sat
    addVec(0, 32'h4, 0, 32'd32000, 0);
    addVec(0, 32'h4, 0, 32'd32767, 0);
    addVec(1, 32'h0, -32'sd70000, 0, 0);           // -37233 clamps to -32768
    addVec(0, 32'h4, 0, 32'hFFFF_8000, 0);
    addVec(0, 32'h8, 0, 32'h5, 0);
    addVec(1, 32'hC, 32'h2, 0, 0);                 // clear sat
    addVec(0, 32'h8, 0, 32'h1, 0);
    addVec(1, 32'hC, 32'h1, 0, 0);
    for (int i = 0; i < 8; i++) addVec(1, 32'h0, 32'd1, 0, 0);
    addVec(0, 32'h8, 0, 32'h0000_0802, 0);         // full
    addVec(1, 32'h0, 32'd1, 0, 1);                 // push when full
    for (int i = 1; i <= 8; i++) addVec(0, 32'h4, 0, 32'(i), 0);
    addVec(0, 32'h4, 0, 32'd0, 1);                 // pop when empty
    addVec(1, 32'h0, 32'd0, 0, 0);                 // predictor held at 8
    addVec(0, 32'h4, 0, 32'd8, 0);
    addVec(1, 32'h4, 32'd3, 0, 1);
    addVec(1, 32'h8, 32'd3, 0, 1);
    addVec(0, 32'h0, 0, 32'd0, 1);
    addVec(0, 32'hC, 0, 32'd0, 1);
    addVec(0, 32'h10, 0, 32'd0, 1);
    addVec(1, 32'h10, 32'd5, 0, 1);
    addVec(0, 32'h8, 0, 32'h1, 0);
    for (int i = 0; i < 3; i++) addVec(1, 32'h0, 32'd1, 0, 0);
    addVec(0, 32'h8, 0, 32'h0000_0300, 0);
    addVec(1, 32'hC, 32'h5, 0, 0);                 // flush + predictor clear
    addVec(0, 32'h8, 0, 32'h1, 0);
    addVec(1, 32'h0, 32'd7, 0, 0);
    addVec(0, 32'h4, 0, 32'd7, 0);

    apb.PSELx = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    PRESETn = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("rst_pready",   32'(apb.PREADY), 32'd1);
    checkOutput("rst_pslverr",  32'(apb.PSLVERR), 32'd0);
    checkOutput("rst_prdata",   apb.PRDATA, 32'd0);
    checkOutput("rst_estados",  32'(estados), 32'd0);
    checkOutput("rst_contador", 32'(contador), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
      checkOutput($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
      if (!vecs[i].wr) checkOutput($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
    end

    // Protocol abort: PSELx dropped during the wait cycle, DIFF must not land.
    @(posedge PCLK); #1;
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 32'h0; apb.PWDATA = 32'd9;
    @(posedge PCLK); #1;
    checkOutput("abort_estados_setup", 32'(estados), 32'd1);
    apb.PSELx = 1'b0;
    @(posedge PCLK); #1;
    checkOutput("abort_pready", 32'(apb.PREADY), 32'd1);
    checkOutput("abort_estados", 32'(estados), 32'd0);
    checkOutput("abort_contador", 32'(contador), 32'd0);
    applyStimulus(0, 32'h8, 0, rd, er);
    checkOutput("abort_status", rd, 32'h1);

    // Reset asserted during the wait cycle of a DIFF write with two queued.
    applyStimulus(1, 32'h0, 32'd2, rd, er);
    applyStimulus(1, 32'h0, 32'd2, rd, er);
    checkOutput("pre_reset_contador", 32'(contador), 32'd2);
    @(posedge PCLK); #1;
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 32'h0; apb.PWDATA = 32'd50;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    checkOutput("midrst_wait_pready", 32'(apb.PREADY), 32'd0);
    #2 PRESETn = 1'b1;
    #1;
    checkOutput("midrst_pready",   32'(apb.PREADY), 32'd1);
    checkOutput("midrst_estados",  32'(estados), 32'd0);
    checkOutput("midrst_contador", 32'(contador), 32'd0);
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b0;
    applyStimulus(0, 32'h8, 0, rd, er);
    checkOutput("post_reset_status", rd, 32'h1);
    checkOutput("post_reset_err", 32'(er), 32'd0);
    applyStimulus(1, 32'h0, 32'd5, rd, er);
    applyStimulus(0, 32'h4, 0, rd, er);
    checkOutput("post_reset_pred", rd, 32'd5);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
